// File: rtl/t07_mem_addr_arbiter.sv
// rtl/t07_mem_addr_arbiter.sv - N-channel memory address arbiter with early-address bypass
//
// Arbitrates NUM_REQ requestors onto one memory address bus. Channel 0 is
// instruction fetch and supplies the idle default address. Once a channel
// wins, the transaction runs to completion through IDLE -> ISSUE -> WAIT
// regardless of what the requestor does with its request line.
//
// Ports:
//   clk, nrst      clock, asynchronous active-low reset
//   req_i          per-channel request level
//   addr_i         per-channel registered address, channel k at [k*ADDR_W +: ADDR_W]
//   addr_comb_i    per-channel combinational early address, same packing
//   mem_busy_i     memory cannot accept the request this cycle
//   mem_ack_i      memory transaction complete (single-cycle pulse)
//   addr_o         address to memory
//   mem_req_o      request to memory (high throughout ISSUE)
//   grant_o        one-hot owner of the current transaction
//   done_o         single-cycle completion pulse to the owner

module t07_mem_addr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int NUM_REQ = 2,
    parameter int RR_MODE = 0
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_comb_i,
    input  logic                      mem_busy_i,
    input  logic                      mem_ack_i,
    output logic [ADDR_W-1:0]         addr_o,
    output logic                      mem_req_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        done_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]  latch_q, latch_d;
    logic [IDX_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  comb_sel;

    // Early address of the current owner; only meaningful outside IDLE.
    assign comb_sel = addr_comb_i[int'(gidx_q)*ADDR_W +: ADDR_W];

    // Winner selection. Loops run from the far end downward so the last hit
    // written is the one closest to the search start.
    always_comb begin
        int j;
        win_idx = '0;
        j       = 0;
        if (RR_MODE == 0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    win_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(ptr_q) + k;
                if (j >= NUM_REQ) begin
                    j = j - NUM_REQ;
                end
                if (req_i[j]) begin
                    win_idx = IDX_W'(j);
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            latch_q <= latch_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        latch_d = latch_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = ISSUE;
                    gidx_d  = win_idx;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            ISSUE: begin
                // Keep tracking the early address so the held value is the
                // one presented on the cycle memory finally accepted.
                latch_d = comb_sel;
                if (!mem_busy_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        addr_o    = addr_i[ADDR_W-1:0];
        mem_req_o = 1'b0;
        done_o    = '0;
        case (state_q)
            IDLE: begin
                addr_o = addr_i[ADDR_W-1:0];
            end
            ISSUE: begin
                addr_o    = comb_sel;
                mem_req_o = 1'b1;
            end
            WAIT: begin
                addr_o = latch_q;
                if (mem_ack_i) begin
                    done_o = grant_q;
                end
            end
            default: begin
                addr_o = addr_i[ADDR_W-1:0];
            end
        endcase
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_t07_mem_addr_arbiter.sv
// tb/tb_t07_mem_addr_arbiter.sv - testbench for t07_mem_addr_arbiter (fixed and round-robin)

module tb_t07_mem_addr_arbiter;

    logic         clk = 1'b0;
    logic         nrst;
    logic [3:0]   req;
    logic [127:0] addr_r;
    logic [127:0] addr_c;
    logic         busy;
    logic         ack;

    logic [31:0]  addr_f, addr_rr;
    logic         mreq_f, mreq_rr;
    logic [3:0]   grant_f, grant_rr;
    logic [3:0]   done_f, done_rr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t07_mem_addr_arbiter #(.ADDR_W(32), .NUM_REQ(4), .RR_MODE(0)) dut_fix (
        .clk(clk), .nrst(nrst), .req_i(req), .addr_i(addr_r), .addr_comb_i(addr_c),
        .mem_busy_i(busy), .mem_ack_i(ack), .addr_o(addr_f), .mem_req_o(mreq_f),
        .grant_o(grant_f), .done_o(done_f)
    );

    t07_mem_addr_arbiter #(.ADDR_W(32), .NUM_REQ(4), .RR_MODE(1)) dut_rr (
        .clk(clk), .nrst(nrst), .req_i(req), .addr_i(addr_r), .addr_comb_i(addr_c),
        .mem_busy_i(busy), .mem_ack_i(ack), .addr_o(addr_rr), .mem_req_o(mreq_rr),
        .grant_o(grant_rr), .done_o(done_rr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_phase;   // 0 idle, 1 issue, 2 wait
    int          m_gf, m_gr, m_ptr;
    logic [31:0] m_lat_f, m_lat_r;

    function automatic int lowest(input logic [3:0] x);
        logic [3:0] oh;
        oh = x & (~x + 4'd1);
        return $clog2(oh);
    endfunction

    function automatic int rr_pick(input logic [3:0] x, input int p);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {x, x} >> p;
        rot = dbl[3:0];
        return (lowest(rot) + p) % 4;
    endfunction

    function automatic logic [31:0] lane(input logic [127:0] v, input int k);
        return v[k*32 +: 32];
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_phase = 0; m_gf = 0; m_gr = 0; m_ptr = 0; m_lat_f = 0; m_lat_r = 0;
        end else begin
            case (m_phase)
                0: if (req != 4'b0) begin
                    m_gf    = lowest(req);
                    m_gr    = rr_pick(req, m_ptr);
                    m_phase = 1;
                end
                1: begin
                    m_lat_f = lane(addr_c, m_gf);
                    m_lat_r = lane(addr_c, m_gr);
                    if (!busy) m_phase = 2;
                end
                default: if (ack) begin
                    m_ptr   = (m_gr + 1) % 4;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic cmp_one(input string nm, input int g, input logic [31:0] lat,
                           input logic [31:0] a, input logic mr,
                           input logic [3:0] gr, input logic [3:0] dn);
        logic [31:0] ea;
        logic        emr;
        logic [3:0]  eg, ed;
        ea = lane(addr_r, 0); emr = 1'b0; eg = 4'b0; ed = 4'b0;
        if (m_phase == 1) begin
            ea = lane(addr_c, g); emr = 1'b1; eg = 4'b1 << g;
        end else if (m_phase == 2) begin
            ea = lat; eg = 4'b1 << g;
            if (ack) ed = eg;
        end
        check({nm, "_addr"},  a, ea);
        check({nm, "_mreq"},  32'(mr), 32'(emr));
        check({nm, "_grant"}, 32'(gr), 32'(eg));
        check({nm, "_done"},  32'(dn), 32'(ed));
    endtask

    always @(negedge clk) begin
        cmp_one("fix", m_gf, m_lat_f, addr_f, mreq_f, grant_f, done_f);
        cmp_one("rr",  m_gr, m_lat_r, addr_rr, mreq_rr, grant_rr, done_rr);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [3:0] r, input int busy_n, input bit drop,
                       output logic [3:0] gf, output logic [3:0] gr, output logic [3:0] dn);
        req  = r;
        busy = (busy_n > 0);
        step();                                  // ISSUE
        gf = grant_f;
        gr = grant_rr;
        for (int i = 0; i < busy_n; i++) begin
            addr_c = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("stall_mreq", 32'(mreq_f), 32'd1);
        busy = 1'b0;
        step();                                  // WAIT
        if (drop) req = 4'b0;
        addr_c = {$urandom, $urandom, $urandom, $urandom};
        step();                                  // still WAIT
        ack = 1'b1;
        #2;
        dn = done_rr;
        step();                                  // IDLE
        ack = 1'b0;
    endtask

    logic [3:0] gf, gr, dn;
    logic [3:0] rr_exp [5];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        nrst = 1'b0; req = 4'b0; busy = 1'b0; ack = 1'b0;
        addr_r = {32'h3000, 32'h2000, 32'h1000, 32'h0};
        addr_c = {32'h3300, 32'h2200, 32'h1100, 32'h40};
        step(); step();
        check("rst_grant", 32'(grant_f), 32'd0);
        check("rst_mreq",  32'(mreq_f),  32'd0);
        nrst = 1'b1;
        step();

        // Round-robin walk with all channels requesting.
        for (int t = 0; t < 5; t++) begin
            txn(4'b1111, 0, 1'b0, gf, gr, dn);
            check("rr_seq", 32'(gr), 32'(rr_exp[t]));
            check("rr_fix_side", 32'(gf), 32'd1);
        end

        // Fixed priority ignores fairness.
        for (int t = 0; t < 3; t++) begin
            txn(4'b1110, 0, 1'b0, gf, gr, dn);
            check("fix_prio", 32'(gf), 32'b0010);
        end
        req = 4'b0;
        step();

        // Single fetch with early address bypass then hold.
        addr_c[31:0] = 32'h40;
        req = 4'b0001;
        step();                                  // ISSUE
        #2;
        check("fetch_issue_addr", addr_f, 32'h40);
        check("fetch_issue_mreq", 32'(mreq_f), 32'd1);
        req = 4'b0;
        step();                                  // WAIT
        addr_c[31:0] = 32'h44;
        #2;
        check("fetch_wait_addr", addr_f, 32'h40);
        check("fetch_wait_mreq", 32'(mreq_f), 32'd0);
        ack = 1'b1;
        #2;
        check("fetch_done", 32'(done_f), 32'b0001);
        step();
        ack = 1'b0;
        #2;
        check("fetch_done_clr", 32'(done_f), 32'd0);
        check("fetch_grant_clr", 32'(grant_f), 32'd0);

        // Busy stall for three cycles.
        txn(4'b0001, 3, 1'b0, gf, gr, dn);
        check("stall_grant", 32'(gf), 32'b0001);

        // Request dropped during WAIT still completes.
        txn(4'b0100, 0, 1'b1, gf, gr, dn);
        check("drop_done", 32'(dn), 32'b0100);

        // Stray ack in IDLE.
        req = 4'b0;
        ack = 1'b1;
        #2;
        check("stray_done", 32'(done_f), 32'd0);
        step();
        ack = 1'b0;
        #2;
        check("stray_mreq",  32'(mreq_f),  32'd0);
        check("stray_grant", 32'(grant_rr), 32'd0);

        // Reset in the middle of WAIT.
        req = 4'b0010;
        step();                                  // ISSUE
        step();                                  // WAIT
        addr_r[31:0] = 32'h100;
        ack = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        check("rstw_grant", 32'(grant_f), 32'd0);
        check("rstw_mreq",  32'(mreq_f),  32'd0);
        check("rstw_done",  32'(done_f),  32'd0);
        check("rstw_addr",  addr_f, 32'h100);
        step();
        ack = 1'b0;
        req = 4'b0;
        step();
        nrst = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
